// File: rtl/user_logic_bus_arbiter_pkg.sv
// Shared constants for the user_logic bus arbiter: FSM encodings, error data and limits.
package user_logic_bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int ARB_MAX_MASTERS = 4;
    localparam int ARB_MAX_DWIDTH  = 64;

    localparam logic [ARB_MAX_DWIDTH-1:0] ARB_ERR_DATA = '1;

    // Wraps a rotated master index back into 0..n-1; idx never exceeds 2*n-1.
    function automatic logic [1:0] arb_wrap(input int idx, input int n);
        return (idx >= n) ? 2'(idx - n) : 2'(idx);
    endfunction

endpackage

// File: rtl/user_logic_rr_picker.sv
// Combinational round-robin priority rotator: first requester after last_grant, with wrap.
module user_logic_rr_picker
    import user_logic_bus_arbiter_pkg::*;
#(
    parameter int C_NUM_MASTERS = 2
) (
    input  logic [C_NUM_MASTERS-1:0] req_i,
    input  logic [1:0]               last_grant_i,
    output logic [1:0]               winner_o,
    output logic                     valid_o
);

    logic [ARB_MAX_MASTERS-1:0] reqPad;
    logic [1:0]                 candidate;

    assign reqPad = ARB_MAX_MASTERS'(req_i);

    always_comb begin
        winner_o  = '0;
        valid_o   = 1'b0;
        candidate = '0;
        for (int k = 1; k <= C_NUM_MASTERS; k++) begin
            candidate = arb_wrap(int'(last_grant_i) + k, C_NUM_MASTERS);
            if (!valid_o && reqPad[candidate]) begin
                valid_o  = 1'b1;
                winner_o = candidate;
            end
        end
    end

endmodule

// File: rtl/user_logic_bus_arbiter.sv
// Round-robin arbiter sharing one user_logic slave between C_NUM_MASTERS requesters.
// Define ARB_TIMEOUT_EN to add an ack timeout that completes the transfer with M_Err set.
module user_logic_bus_arbiter
    import user_logic_bus_arbiter_pkg::*;
#(
    parameter int C_NUM_MASTERS = 2,
    parameter int C_SLV_DWIDTH  = 32,
    parameter int C_SLV_AWIDTH  = 5,
    parameter int C_TIMEOUT     = 16
) (
    input  logic                                    Bus2IP_Clk,
    input  logic                                    Bus2IP_Resetn,
    input  logic [C_NUM_MASTERS-1:0]                M_Req,
    input  logic [C_NUM_MASTERS-1:0]                M_Wr,
    input  logic [C_NUM_MASTERS*C_SLV_AWIDTH-1:0]   M_Addr,
    input  logic [C_NUM_MASTERS*C_SLV_DWIDTH-1:0]   M_Data,
    input  logic [C_NUM_MASTERS*C_SLV_DWIDTH/8-1:0] M_BE,
    output logic [C_NUM_MASTERS-1:0]                M_Done,
    output logic                                    M_Err,
    output logic [C_SLV_DWIDTH-1:0]                 M_RdData,
    output logic                                    Arb_Busy,
    output logic [C_SLV_AWIDTH-1:0]                 Bus2IP_Addr,
    output logic [C_SLV_DWIDTH-1:0]                 Bus2IP_Data,
    output logic [C_SLV_DWIDTH/8-1:0]               Bus2IP_BE,
    output logic                                    Bus2IP_WrCE,
    output logic                                    Bus2IP_RdCE,
    input  logic [C_SLV_DWIDTH-1:0]                 IP2Bus_Data,
    input  logic                                    IP2Bus_Ack
);

    localparam int BEW = C_SLV_DWIDTH / 8;

    if (C_NUM_MASTERS < 2 || C_NUM_MASTERS > ARB_MAX_MASTERS ||
        C_SLV_DWIDTH % 8 != 0 || C_SLV_DWIDTH > ARB_MAX_DWIDTH ||
        C_TIMEOUT < 2 || C_TIMEOUT > 255) begin : g_bad_config
        $error("user_logic_bus_arbiter: unsupported parameter combination");
    end

    logic [1:0]              state_q, state_d;
    logic [1:0]              winner_q, winner_d;
    logic [1:0]              lastGrant_q, lastGrant_d;
    logic                    wr_q, wr_d;
    logic [C_SLV_AWIDTH-1:0] addr_q, addr_d;
    logic [C_SLV_DWIDTH-1:0] data_q, data_d;
    logic [BEW-1:0]          be_q, be_d;
    logic [C_SLV_DWIDTH-1:0] rdData_q, rdData_d;

    logic [1:0] pickWinner;
    logic       pickValid;
    logic       ackTimeout;
    logic       inBus;
    logic       inDone;

    user_logic_rr_picker #(
        .C_NUM_MASTERS(C_NUM_MASTERS)
    ) u_picker (
        .req_i       (M_Req),
        .last_grant_i(lastGrant_q),
        .winner_o    (pickWinner),
        .valid_o     (pickValid)
    );

    assign inBus  = (state_q == ST_BUS);
    assign inDone = (state_q == ST_DONE);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(C_TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       err_q;

    // Counter is held at zero outside BUS, so it always starts a transfer cleared.
    always_comb begin
        cnt_d = '0;
        if (inBus && !IP2Bus_Ack) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign ackTimeout = inBus && !IP2Bus_Ack && (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (inBus) begin
                err_q <= ackTimeout;
            end
        end
    end

    assign M_Err = inDone & err_q;
`else
    assign ackTimeout = 1'b0;
    assign M_Err      = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        lastGrant_d = lastGrant_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        be_d        = be_q;
        rdData_d    = rdData_q;
        case (state_q)
            ST_IDLE: begin
                if (pickValid) begin
                    winner_d = pickWinner;
                    state_d  = ST_BUS;
                    for (int i = 0; i < C_NUM_MASTERS; i++) begin
                        if (pickWinner == 2'(i)) begin
                            wr_d   = M_Wr[i];
                            addr_d = M_Addr[i*C_SLV_AWIDTH +: C_SLV_AWIDTH];
                            data_d = M_Data[i*C_SLV_DWIDTH +: C_SLV_DWIDTH];
                            be_d   = M_BE[i*BEW +: BEW];
                        end
                    end
                end
            end
            ST_BUS: begin
                if (IP2Bus_Ack) begin
                    rdData_d    = wr_q ? '0 : IP2Bus_Data;
                    lastGrant_d = winner_q;
                    state_d     = ST_DONE;
                end else if (ackTimeout) begin
                    rdData_d    = ARB_ERR_DATA[C_SLV_DWIDTH-1:0];
                    lastGrant_d = winner_q;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            state_q     <= ST_IDLE;
            winner_q    <= '0;
            lastGrant_q <= 2'(C_NUM_MASTERS - 1);
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
            rdData_q    <= '0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            lastGrant_q <= lastGrant_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= be_d;
            rdData_q    <= rdData_d;
        end
    end

    // Slave-side outputs are forced to zero whenever no transfer is on the bus.
    assign Arb_Busy    = (state_q != ST_IDLE);
    assign Bus2IP_Addr = inBus ? addr_q : '0;
    assign Bus2IP_Data = inBus ? data_q : '0;
    assign Bus2IP_BE   = inBus ? be_q : '0;
    assign Bus2IP_WrCE = inBus & wr_q;
    assign Bus2IP_RdCE = inBus & ~wr_q;
    assign M_RdData    = inDone ? rdData_q : '0;

    always_comb begin
        M_Done = '0;
        for (int i = 0; i < C_NUM_MASTERS; i++) begin
            if (inDone && winner_q == 2'(i)) begin
                M_Done[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_user_logic_bus_arbiter.sv
// Self-checking bench for user_logic_bus_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level round-robin and register-file model.
module tb_user_logic_bus_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int BW = DW / 8;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    wr = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] data = '0;
    logic [N*BW-1:0] be = '0;
    logic [N-1:0]    done;
    logic            err;
    logic [DW-1:0]   rdData;
    logic            busy;
    logic [AW-1:0]   bAddr;
    logic [DW-1:0]   bData;
    logic [BW-1:0]   bBe;
    logic            wrCe;
    logic            rdCe;
    logic [DW-1:0]   ipData;
    logic            ipAck;

    int total = 0;
    int bad = 0;

    int   ackMode = 0;
    int   ackDelay = 1;
    logic spurious = 1'b0;
    int   ceCnt = 0;

    logic [DW-1:0] periphRegs [8];
    logic [DW-1:0] modelRegs [8];

    user_logic_bus_arbiter #(
        .C_NUM_MASTERS(N),
        .C_SLV_DWIDTH (DW),
        .C_SLV_AWIDTH (AW),
        .C_TIMEOUT    (4)
    ) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Resetn(resetn),
        .M_Req        (req),
        .M_Wr         (wr),
        .M_Addr       (addr),
        .M_Data       (data),
        .M_BE         (be),
        .M_Done       (done),
        .M_Err        (err),
        .M_RdData     (rdData),
        .Arb_Busy     (busy),
        .Bus2IP_Addr  (bAddr),
        .Bus2IP_Data  (bData),
        .Bus2IP_BE    (bBe),
        .Bus2IP_WrCE  (wrCe),
        .Bus2IP_RdCE  (rdCe),
        .IP2Bus_Data  (ipData),
        .IP2Bus_Ack   (ipAck)
    );

    always #5 clk = ~clk;

    // Peripheral model: 8-register file, ack immediate, after ackDelay CE cycles, or never.
    always @(posedge clk) ceCnt <= (wrCe | rdCe) ? ceCnt + 1 : 0;

    assign ipAck = (wrCe | rdCe) ? ((ackMode == 0) ? 1'b1 :
                                    (ackMode == 1) ? (ceCnt == ackDelay - 1) : 1'b0)
                                 : spurious;
    assign ipData = rdCe ? periphRegs[bAddr[4:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) periphRegs[i] <= 32'h0000_00C1 + 32'(i);
        end else if (wrCe && ipAck) begin
            for (int b = 0; b < BW; b++)
                if (bBe[b]) periphRegs[bAddr[4:2]][8*b +: 8] <= bData[8*b +: 8];
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic setMaster(input int i, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [BW-1:0] b);
        req[i] = 1'b1;
        wr[i] = w;
        addr[i*AW +: AW] = a;
        data[i*DW +: DW] = d;
        be[i*BW +: BW] = b;
    endtask

    task automatic applyStimulus_reset(input int cycles);
        @(negedge clk);
        resetn = 1'b0;
        repeat (cycles) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) modelRegs[i] = 32'h0000_00C1 + 32'(i);
    endtask

    task automatic test_reset();
        ackMode = 0;
        spurious = 1'b0;
        resetn = 1'b0;
        req = '1;
        repeat (3) @(negedge clk);
        total++;
        if ({done, err, rdData, busy, bAddr, bData, bBe, wrCe, rdCe} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%h want=0",
                     {done, err, rdData, busy, bAddr, bData, bBe, wrCe, rdCe});
        end
        req = '0;
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) modelRegs[i] = 32'h0000_00C1 + 32'(i);
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_idle busy=%b want=0", busy);
        end
    endtask

    task automatic test_single_write();
        setMaster(0, 1'b1, 5'h04, 32'hA5A5_1234, 4'hF);
        @(negedge clk);
        total++;
        if ({wrCe, rdCe, bAddr, bData, bBe, busy, done} !==
            {1'b1, 1'b0, 5'h04, 32'hA5A5_1234, 4'hF, 1'b1, 3'b000}) begin
            bad++;
            $display("[TB] FAIL write_bus wr=%b rd=%b a=%h d=%h be=%h busy=%b done=%b want 1 0 04 a5a51234 f 1 000",
                     wrCe, rdCe, bAddr, bData, bBe, busy, done);
        end
        @(negedge clk);
        total++;
        if ({done, err, wrCe, rdCe, rdData} !== {3'b001, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("[TB] FAIL write_done done=%b err=%b wr=%b rd=%b rdData=%h want 001 0 0 0 0",
                     done, err, wrCe, rdCe, rdData);
        end
        req = '0;
        @(negedge clk);
        total++;
        if ({done, busy, wrCe, rdCe} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL write_idle done=%b busy=%b wr=%b rd=%b want all 0", done, busy, wrCe, rdCe);
        end
    endtask

    task automatic test_read();
        setMaster(1, 1'b0, 5'h08, 32'h0, 4'hF);
        @(negedge clk);
        total++;
        if ({rdCe, wrCe, bAddr, done} !== {1'b1, 1'b0, 5'h08, 3'b000}) begin
            bad++;
            $display("[TB] FAIL read_bus rd=%b wr=%b a=%h done=%b want 1 0 08 000", rdCe, wrCe, bAddr, done);
        end
        @(negedge clk);
        total++;
        if ({done, rdData, err, rdCe} !== {3'b010, 32'h0000_00C3, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL read_done done=%b rdData=%h err=%b rd=%b want 010 000000c3 0 0",
                     done, rdData, err, rdCe);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int order[$];
        int got;
        applyStimulus_reset(2);
        setMaster(0, 1'b1, 5'h00, 32'h1111_0000, 4'hF);
        setMaster(1, 1'b1, 5'h10, 32'h2222_0000, 4'hF);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            for (int m = 0; m < N; m++) if (done[m]) order.push_back(m);
            if (done !== '0) begin
                total++;
                if (err !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL fair_err err=%b want=0", err);
                end
            end
        end
        req = '0;
        total++;
        if (order.size() != 4) begin
            bad++;
            $display("[TB] FAIL fair_count got=%0d want=4", order.size());
        end
        for (int k = 0; k < 4; k++) begin
            got = (k < order.size()) ? order[k] : -1;
            total++;
            if (got != k % 2) begin
                bad++;
                $display("[TB] FAIL fair_order idx=%0d got=%0d want=%0d", k, got, k % 2);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_withdraw_abort();
        // M1 raises and drops its request entirely inside M0's BUS/DONE window.
        setMaster(0, 1'b1, 5'h0C, 32'hCAFE_0001, 4'hF);
        @(negedge clk);
        setMaster(1, 1'b0, 5'h10, 32'h0, 4'hF);
        @(negedge clk);
        total++;
        if (done !== 3'b001) begin
            bad++;
            $display("[TB] FAIL withdraw_first done=%b want=001", done);
        end
        req[1] = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({wrCe, bAddr} !== {1'b1, 5'h0C}) begin
            bad++;
            $display("[TB] FAIL withdraw_skip wr=%b a=%h want 1 0c", wrCe, bAddr);
        end
        @(negedge clk);
        total++;
        if (done !== 3'b001) begin
            bad++;
            $display("[TB] FAIL withdraw_done done=%b want=001", done);
        end
        req = '0;
        @(negedge clk);

        setMaster(1, 1'b0, 5'h14, 32'h0, 4'hF);
        @(negedge clk);
        total++;
        if (rdCe !== 1'b1) begin
            bad++;
            $display("[TB] FAIL abort_bus rd=%b want=1", rdCe);
        end
        resetn = 1'b0;
        setMaster(0, 1'b1, 5'h18, 32'h5555_AAAA, 4'h3);
        @(negedge clk);
        total++;
        if ({done, err, rdData, busy, bAddr, bData, bBe, wrCe, rdCe} !== '0) begin
            bad++;
            $display("[TB] FAIL abort_outputs got=%h want=0",
                     {done, err, rdData, busy, bAddr, bData, bBe, wrCe, rdCe});
        end
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) modelRegs[i] = 32'h0000_00C1 + 32'(i);
        @(negedge clk);
        total++;
        if ({wrCe, bAddr, bData, bBe, done} !== {1'b1, 5'h18, 32'h5555_AAAA, 4'h3, 3'b000}) begin
            bad++;
            $display("[TB] FAIL abort_regrant wr=%b a=%h d=%h be=%h done=%b want 1 18 5555aaaa 3 000",
                     wrCe, bAddr, bData, bBe, done);
        end
        @(negedge clk);
        total++;
        if (done !== 3'b001) begin
            bad++;
            $display("[TB] FAIL abort_done done=%b want=001", done);
        end
        req = '0;
        @(negedge clk);
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int ceCycles = 0;
        logic gotDone = 1'b0;
        logic [N-1:0] doneSeen = '0;
        logic errSeen = 1'b0;
        logic [DW-1:0] dataSeen = '0;
        ackMode = 2;
        setMaster(1, 1'b0, 5'h00, 32'h0, 4'hF);
        for (int c = 0; c < 40 && !gotDone; c++) begin
            @(negedge clk);
            if (wrCe | rdCe) ceCycles++;
            if (done !== '0) begin
                gotDone = 1'b1;
                doneSeen = done;
                errSeen = err;
                dataSeen = rdData;
                req = '0;
            end
        end
        total++;
        if (!gotDone) begin
            bad++;
            $display("[TB] FAIL timeout_wait no M_Done within 40 cycles");
        end
        total++;
        if (ceCycles != 4) begin
            bad++;
            $display("[TB] FAIL timeout_ce_cycles got=%0d want=4", ceCycles);
        end
        total++;
        if ({doneSeen, errSeen, dataSeen} !== {3'b010, 1'b1, 32'hFFFF_FFFF}) begin
            bad++;
            $display("[TB] FAIL timeout_done done=%b err=%b rdData=%h want 010 1 ffffffff",
                     doneSeen, errSeen, dataSeen);
        end
        req = '0;
        ackMode = 0;
        @(negedge clk);
    endtask
`else
    task automatic test_delayed_ack();
        int ceCycles = 0;
        logic gotDone = 1'b0;
        logic [N-1:0] doneSeen = '0;
        logic errSeen = 1'b0;
        ackMode = 1;
        ackDelay = 10;
        setMaster(2, 1'b1, 5'h1C, 32'h0BAD_F00D, 4'hC);
        for (int c = 0; c < 40 && !gotDone; c++) begin
            @(negedge clk);
            if (wrCe | rdCe) ceCycles++;
            if (done !== '0) begin
                gotDone = 1'b1;
                doneSeen = done;
                errSeen = err;
                req = '0;
            end
        end
        total++;
        if (!gotDone) begin
            bad++;
            $display("[TB] FAIL delayed_wait no M_Done within 40 cycles");
        end
        total++;
        if (ceCycles != 10) begin
            bad++;
            $display("[TB] FAIL delayed_ce_cycles got=%0d want=10", ceCycles);
        end
        total++;
        if ({doneSeen, errSeen} !== {3'b100, 1'b0}) begin
            bad++;
            $display("[TB] FAIL delayed_done done=%b err=%b want 100 0", doneSeen, errSeen);
        end
        req = '0;
        ackMode = 0;
        ackDelay = 1;
        @(negedge clk);
    endtask
`endif

    task automatic test_random();
        logic          pending [N];
        logic          txWr [N];
        logic [AW-1:0] txAddr [N];
        logic [DW-1:0] txData [N];
        logic [BW-1:0] txBe [N];
        int            waitCnt [N];
        int            lastGrant = N - 1;
        int            expWinner = -1;
        int            txCount = 0;
        int            m;
        logic          prevCe = 1'b0;
        logic [DW-1:0] expData;
        logic [N-1:0]  expDone;
        logic          justDone;

        applyStimulus_reset(2);
        ackMode = 1;
        for (int i = 0; i < N; i++) begin
            pending[i] = 1'b0;
            waitCnt[i] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            justDone = 1'b0;
            total++;
            if (wrCe && rdCe) begin
                bad++;
                $display("[TB] FAIL rand_ce_exclusive cycle=%0d both CEs high", cyc);
            end
            if ((wrCe | rdCe) && !prevCe) begin
                // Requests present at the edge just passed decide this grant.
                expWinner = -1;
                for (int k = 1; k <= N; k++) begin
                    m = (lastGrant + k) % N;
                    if (expWinner < 0 && req[m]) expWinner = m;
                end
                total++;
                if (expWinner < 0) begin
                    bad++;
                    $display("[TB] FAIL rand_grant cycle=%0d bus started with no request", cyc);
                end else if ({wrCe, bAddr, bData, bBe} !==
                             {txWr[expWinner], txAddr[expWinner], txData[expWinner], txBe[expWinner]}) begin
                    bad++;
                    $display("[TB] FAIL rand_grant cycle=%0d got wr=%b a=%h d=%h be=%h want master %0d wr=%b a=%h d=%h be=%h",
                             cyc, wrCe, bAddr, bData, bBe, expWinner, txWr[expWinner],
                             txAddr[expWinner], txData[expWinner], txBe[expWinner]);
                end
            end
            prevCe = wrCe | rdCe;
            if (done !== '0) begin
                total++;
                if (expWinner < 0) begin
                    bad++;
                    $display("[TB] FAIL rand_done cycle=%0d done=%b without a transfer", cyc, done);
                end else begin
                    expDone = N'(1 << expWinner);
                    expData = txWr[expWinner] ? '0 : modelRegs[txAddr[expWinner][4:2]];
                    if ({done, err, rdData} !== {expDone, 1'b0, expData}) begin
                        bad++;
                        $display("[TB] FAIL rand_done cycle=%0d done=%b err=%b rdData=%h want %b 0 %h",
                                 cyc, done, err, rdData, expDone, expData);
                    end
                    if (txWr[expWinner])
                        for (int b = 0; b < BW; b++)
                            if (txBe[expWinner][b])
                                modelRegs[txAddr[expWinner][4:2]][8*b +: 8] = txData[expWinner][8*b +: 8];
                    for (int i = 0; i < N; i++) begin
                        if (i != expWinner && pending[i]) begin
                            waitCnt[i]++;
                            total++;
                            if (waitCnt[i] > N - 1) begin
                                bad++;
                                $display("[TB] FAIL rand_fairness master=%0d waited=%0d want<=%0d",
                                         i, waitCnt[i], N - 1);
                            end
                        end
                    end
                    lastGrant = expWinner;
                    waitCnt[expWinner] = 0;
                    pending[expWinner] = 1'b0;
                    req[expWinner] = 1'b0;
                    justDone = 1'b1;
                    txCount++;
                end
                expWinner = -1;
            end
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && !justDone && cyc < 370 && $urandom_range(0, 3) == 0) begin
                    pending[i] = 1'b1;
                    txWr[i] = 1'($urandom_range(0, 1));
                    txAddr[i] = 5'($urandom);
                    txData[i] = $urandom;
                    txBe[i] = 4'($urandom);
                    waitCnt[i] = 0;
                    setMaster(i, txWr[i], txAddr[i], txData[i], txBe[i]);
                end
            end
            if (!(wrCe | rdCe)) ackDelay = $urandom_range(1, 3);
            spurious = 1'($urandom_range(0, 1));
        end
        total++;
        if (pending[0] || pending[1] || pending[2]) begin
            bad++;
            $display("[TB] FAIL rand_drain pending=%b%b%b want 000", pending[2], pending[1], pending[0]);
        end
        total++;
        if (txCount < 20) begin
            bad++;
            $display("[TB] FAIL rand_progress completed=%0d want>=20", txCount);
        end
        req = '0;
        spurious = 1'b0;
        ackMode = 0;
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] starting user_logic_bus_arbiter bench");
        test_reset();
        test_single_write();
        test_read();
        test_fairness();
        test_withdraw_abort();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_delayed_ack();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/user_logic_bus_arbiter.md
Name: user_logic_bus_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one memory-mapped slave register peripheral between up to 4 bus requesters (CPU, DMA, debug).
- Latches the winning request, drives the peripheral's Bus2IP_* slave interface for one transaction, waits for IP2Bus_Ack, then returns read data and a completion pulse to the requester.
- Sits between the master-side interconnect and the 8-register user_logic slave.

Parameters:
- C_NUM_MASTERS, 2, number of requesters (2..4).
- C_SLV_DWIDTH, 32, data width; multiple of 8.
- C_SLV_AWIDTH, 5, address width.
- C_TIMEOUT, 16, ack timeout in cycles (used only with ARB_TIMEOUT_EN); 2..255.

Ports:
- Bus2IP_Clk  in  1  system clock; all logic on rising edge.
- Bus2IP_Resetn  in  1  synchronous active-low reset.
- M_Req  in  C_NUM_MASTERS  per-master request; held until M_Done.
- M_Wr  in  C_NUM_MASTERS  per-master direction, 1 = write, 0 = read.
- M_Addr  in  C_NUM_MASTERS*C_SLV_AWIDTH  packed addresses; master i at [i*AW +: AW].
- M_Data  in  C_NUM_MASTERS*C_SLV_DWIDTH  packed write data.
- M_BE  in  C_NUM_MASTERS*C_SLV_DWIDTH/8  packed byte enables.
- M_Done  out  C_NUM_MASTERS  one-cycle completion pulse to the granted master.
- M_Err  out  1  timeout flag, valid with M_Done.
- M_RdData  out  C_SLV_DWIDTH  read data, valid while any M_Done bit is high.
- Arb_Busy  out  1  high when state is not IDLE.
- Bus2IP_Addr  out  C_SLV_AWIDTH  to peripheral.
- Bus2IP_Data  out  C_SLV_DWIDTH  to peripheral.
- Bus2IP_BE  out  C_SLV_DWIDTH/8  to peripheral.
- Bus2IP_WrCE  out  1  write chip enable.
- Bus2IP_RdCE  out  1  read chip enable.
- IP2Bus_Data  in  C_SLV_DWIDTH  read data from peripheral.
- IP2Bus_Ack  in  1  completion from peripheral; may be combinational from CE.

Behaviour:
- Reset (Bus2IP_Resetn = 0 at a clock edge): state IDLE; all outputs 0; last_grant = C_NUM_MASTERS-1, so master 0 has first priority; timeout counter 0.
- FSM states:
  - IDLE: if M_Req != 0, pick the winner by round robin, searching from last_grant+1 upward with wrap. Register the winner's index, wr, addr, data and BE. Go to BUS. Otherwise stay in IDLE.
  - BUS: drive Bus2IP_Addr/Data/BE from the registers. Assert WrCE if wr = 1, else RdCE. If IP2Bus_Ack = 1 this cycle:
    - capture IP2Bus_Data into M_RdData for reads; M_RdData = 0 for writes;
    - set last_grant = winner;
    - go to DONE.
  - DONE: M_Done[winner] = 1 for exactly one cycle; CEs low; go to IDLE.
- Latency: M_Req sampled at edge 0; CE high in cycle 1; with a same-cycle ack, M_Done is high in cycle 2. Minimum 3 cycles per transaction.
- Bus2IP_* outputs and both CEs are 0 outside BUS. WrCE and RdCE are never high together.
- Requests arriving in BUS or DONE are not sampled until the next IDLE. No preemption.
- A master that drops M_Req before it is granted is simply skipped. Once its request is latched, the transaction completes even if M_Req drops.
- A master that holds M_Req after M_Done competes again. Round robin guarantees that with N masters continuously requesting, each is served within N transactions.
- IP2Bus_Ack outside BUS is ignored.
- Reset asserted in any state aborts the transaction: no M_Done pulse; outputs go to reset values on that edge.
- M_Err is 0 unless ARB_TIMEOUT_EN is defined.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - an 8-bit counter clears on entry to BUS and increments each BUS cycle without ack;
  - when it reaches C_TIMEOUT-1 with no ack, deassert CE next cycle and go to DONE;
  - in DONE, M_Err = 1 alongside M_Done and M_RdData = all ones;
  - last_grant updates as normal.
- Undefined: no counter; BUS waits indefinitely for ack; M_Err tied 0.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE = 2'd0, ST_BUS = 2'd1, ST_DONE = 2'd2;
  - the ARB_ERR_DATA all-ones constant;
  - the maximum master count, 4.
- One sub-module: user_logic_rr_picker, a combinational priority rotator. Inputs: req vector and last_grant. Outputs: winner index and a valid bit.

Test Plan:
- Single write: M0 writes addr 5'h04, data 32'hA5A5_1234, BE 4'hF; ack tied to CE -> WrCE high exactly cycle 1 with those values, M_Done[0] pulses cycle 2, M_Err = 0.
- Read: M1 reads addr 5'h08 while the peripheral returns 32'h0000_00C3 -> RdCE one cycle, M_RdData = 32'h0000_00C3 with M_Done[1].
- Fairness: M0 and M1 both request continuously after reset -> grant order 0, 1, 0, 1; four M_Done pulses within 12 cycles.
- Late withdraw and reset abort: M1 drops M_Req before it is sampled -> no grant to M1; reset pulsed during BUS -> no M_Done, all outputs 0 the next cycle, first grant after reset goes to M0.
- Timeout (ARB_TIMEOUT_EN, C_TIMEOUT = 4): ack held 0 -> CE high 4 cycles, then M_Done with M_Err = 1 and M_RdData = 32'hFFFF_FFFF.
- Delayed ack (macro undefined): ack arrives 10 cycles after CE -> CE held the full 10 cycles, correct completion, no error.
